alu_div_unit: RTL and testbench

//  Multi-cycle iterative divider serving DIV (5'b01000, aluOp DIVA 3'b011).
//  ALU issues an operand pair via start/ready handshake; unit runs restoring

---
 rtl/alu_div_unit.sv | 109 ++++++++++
 tb/tb_alu_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_div_unit.sv
// Multi-cycle restoring divider for the ALU DIV op: start/ready issue, WIDTH shift-subtract steps, done pulse.
// Optional ALU_DIV_SIGNED_EN selects two's-complement truncating division; default build is unsigned.
module alu_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       flags
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_q, dsr_q, rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
  logic             accept, calc_end, dsr_zero;

`ifdef ALU_DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fin = q_neg ? -quo_q : quo_q;
  assign r_fin = r_neg ? -rem_q : rem_q;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = quo_q;
  assign r_fin = rem_q;
`endif

  assign accept   = start && (state == IDLE);
  assign dsr_zero = (divisor == '0);
  assign calc_end = (state == CALC) && (cnt_q == CW'(WIDTH));
  // Full WIDTH+1 subtract: the shifted partial remainder can exceed WIDTH bits
  // when the divisor has its MSB set, so diff[WIDTH] is a true borrow.
  assign diff     = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = dsr_zero ? DONE : CALC;
      CALC: if (calc_end) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      flags     <= '0;
`ifdef ALU_DIV_SIGNED_EN
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd_q <= a_mag;
        dsr_q <= b_mag;
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= '0;
`ifdef ALU_DIV_SIGNED_EN
        q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg <= dividend[WIDTH-1];
`endif
        if (dsr_zero) begin
          quotient  <= '1;
          remainder <= dividend;
          flags     <= 2'b01;
        end
      end else if (state == CALC) begin
        if (!calc_end) begin
          dvd_q <= dvd_q << 1;
          quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          rem_q <= diff[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : diff[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
        end else begin
          quotient  <= q_fin;
          remainder <= r_fin;
          flags     <= {(q_fin == '0), 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_div_unit.sv
// Scoreboard bench for alu_div_unit: driver queues expected results, monitor checks on done.
// Expectations follow ALU_DIV_SIGNED_EN when defined.
module tb_alu_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         ready, busy, done;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   flags;

  alu_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q, r;
    logic [1:0]   f;
    int           t_acc, lat_lo, lat_hi;
  } exp_t;

  typedef struct {
    string        name;
    logic [W-1:0] act, exp;
  } chk_t;

  exp_t sb[$];
  chk_t chk_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  bit   drv_end = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole owner of the counters; evaluates queued level checks and done results.
  initial begin
    exp_t e;
    chk_t c;
    int   lat;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_chk++;
        if (c.act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
        end
      end
      if (done === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          lat = cyc - e.t_acc;
          if (quotient !== e.q || remainder !== e.r || flags !== e.f ||
              lat < e.lat_lo || lat > e.lat_hi) begin
            n_fail++;
            $display("FAIL result: got q=%h r=%h f=%b lat=%0d expected q=%h r=%h f=%b lat=%0d..%0d",
                     quotient, remainder, flags, lat, e.q, e.r, e.f, e.lat_lo, e.lat_hi);
          end
        end
      end
      if (drv_end) begin
        n_chk++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL missing_done: got %0d pending results expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  // Issue one division and wait (bounded) for it to complete.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic [1:0] ef);
    exp_t e;
    int   guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1; dividend = a; divisor = b;
    e.q = eq; e.r = er; e.f = ef;
    e.t_acc  = cyc + 1;
    e.lat_lo = (b == '0) ? 0 : W + 1;
    e.lat_hi = (b == '0) ? 1 : W + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("done_timeout", {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy},  32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_quot",  quotient,       32'd0);
    chk("rst_rem",   remainder,      32'd0);
    chk("rst_flags", {30'b0, flags}, 32'd0);

    do_div(32'd100, 32'd7, 32'd14, 32'd2, 2'b00);
    chk("hold_quot", quotient, 32'd14);
    chk("idle_ready", {31'b0, ready}, 32'd1);
    do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 2'b00);
    do_div(32'd3, 32'd7, 32'd0, 32'd3, 2'b10);
    do_div(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 2'b01);

    // Abort mid-CALC: stray start while busy, then reset; no done may appear.
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    chk("busy_in_calc", {31'b0, busy}, 32'd1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_busy",  {31'b0, busy},  32'd0);
    chk("abort_quot",  quotient,       32'd0);
    repeat (40) @(negedge clk);
    do_div(32'd9, 32'd3, 32'd3, 32'd0, 2'b00);

`ifdef ALU_DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2'b00);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2'b00);
    do_div(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 2'b10);
    do_div(32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2'b01);
`else
    do_div(32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 2'b00);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 2'b10);
    do_div(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 2'b00);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 2'b00);
`endif
    chk("final_ready", {31'b0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    drv_end = 1'b1;
  end
endmodule
